gf256_arith_unit: RTL and testbench
===================================

# gf256_arith_unit

Registered GF(2^8) arithmetic unit for the masked-arithmetic (IPM) coprocessor datapath. It provides `MUL_LANES` independent byte multipliers and a `SQ_LANES`-byte lane-wise squarer. Both operate in the AES field, polynomial x^8+x^4+x^3+x+1 (0x11B), and results are registered once. It replaces the free-standing combinational multiplier and squarer instances inside the IPM engine with a single pipelined block.

## Interface
Parameters:
- `MUL_LANES`, default 3: number of independent 8-bit GF multipliers.
- `SQ_LANES`, default 4: number of byte lanes in the squarer; the squarer bus is `SQ_LANES*8` bits wide.

Ports:
- `clk_i`  in  1: single clock, rising edge.
- `rst_i`  in  1: reset, asynchronous and active-high.
- `valid_i`  in  1: input qualifier; operands are captured only when high.
- `mul_a_i`  in  `MUL_LANES*8`: multiplier operand A; lane m is bits [8m+7:8m].
- `mul_b_i`  in  `MUL_LANES*8`: multiplier operand B, same lane packing.
- `sq_i`  in  `SQ_LANES*8`: squarer operand; lane s is bits [8s+7:8s].
- `mul_o`  out  `MUL_LANES*8`: registered products; lane m = A_m·B_m in GF(2^8).
- `sq_o`  out  `SQ_LANES*8`: registered squares; lane s = (sq_i lane s)^2 in GF(2^8).
- `valid_o`  out  1: high for exactly one cycle per accepted `valid_i`.

## Operation
- Field: GF(2^8) with reduction polynomial 0x11B.
  - Addition is XOR.
  - Multiplication is carry-less multiplication of two 8-bit values into a 15-bit product, reduced modulo 0x11B.
- Multiplier lanes:
  - Fully independent; no carries or interaction between lanes.
  - Each lane is purely combinational ahead of the output register (shift-and-add or a bit-matrix form are both acceptable).
- Squarer lanes:
  - Squaring is GF-linear: spread input bits b_k to product bit 2k (zeros in odd positions), then reduce the 15-bit value modulo 0x11B.
  - Lanes are independent and byte order has no effect.
  - The squarer must not instantiate a general multiplier; it is fixed XOR logic only.
- Identities that must hold for all inputs:
  - x·0 = 0, x·1 = x, and multiplication is commutative.
  - sq(x) equals the multiplier result x·x.
  - sq(a XOR b) = sq(a) XOR sq(b).
- Capture behaviour:
  - When `valid_i` = 1 at a rising edge, `mul_o` and `sq_o` load the results computed from the current operands.
  - When `valid_i` = 0, `mul_o` and `sq_o` hold their previous values.
- Valid behaviour: `valid_o` is the registered copy of `valid_i`, loaded every cycle.
- There is no back-pressure and no busy state; a new operation may be issued every cycle.

## Timing
- Latency:
  - Exactly 1 cycle from a `valid_i`=1 edge to the corresponding `valid_o`=1 and result.
  - Throughput is 1 operation per cycle.
- Reset:
  - While `rst_i`=1, `mul_o`, `sq_o` and `valid_o` are 0 immediately, without waiting for a clock edge.
  - Reset has priority over `valid_i`.
- Reset mid-operation: an operation accepted in the cycle before reset asserts is discarded; after reset deasserts, outputs stay 0 until the next `valid_i`.
- Back-to-back issue: with `valid_i` high on consecutive cycles, outputs update every cycle and `valid_o` stays high continuously.
- Operand changes while `valid_i`=0 have no effect on the outputs.
- Combinational path: the inputs-to-register path is one multiplier depth (about 8 XOR/AND levels plus reduction). No combinational path exists from inputs to outputs.

## Test plan
- Reset: assert `rst_i` asynchronously mid-cycle with nonzero outputs present → `mul_o`, `sq_o` and `valid_o` are 0 before the next edge; after release, they remain 0 with `valid_i`=0.
- Multiplier known-answer: lanes (0x57,0x83), (0x57,0x13), (0x53,0xCA) with `valid_i` pulsed once → one cycle later `mul_o` lanes are 0xC1, 0xFE, 0x01 and `valid_o` is high for one cycle.
- Squarer known-answer: `sq_i` lanes 0x02, 0x03, 0x10, 0x80 → `sq_o` lanes 0x04, 0x05, 0x1B, 0x9A.
- Hold: after the known-answer test, change all operands with `valid_i`=0 for 5 cycles → outputs unchanged and `valid_o`=0.
- Streaming: 1000 random operand sets issued on consecutive cycles → each result matches a software GF(2^8) model one cycle later; `sq` lane s equals `mul(x,x)`; `mul(x,1)`=x and `mul(x,0)`=0 on dedicated lanes.
- Exhaustive: all 65536 (a,b) pairs on lane 0 and all 256 squarer inputs → every result matches the model; `mul(a,b)` = `mul(b,a)`.

Source files
------------

// File: rtl/gf256_arith_unit.sv
// Registered GF(2^8) multiplier lanes and lane-wise squarer over the AES field (0x11B).
// One register stage; results load only on valid_i, valid_o follows valid_i every cycle.
module gf256_arith_unit #(
  parameter int MUL_LANES = 3,
  parameter int SQ_LANES  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [MUL_LANES*8-1:0] mul_a_i,
  input  logic [MUL_LANES*8-1:0] mul_b_i,
  input  logic [SQ_LANES*8-1:0]  sq_i,
  output logic [MUL_LANES*8-1:0] mul_o,
  output logic [SQ_LANES*8-1:0]  sq_o,
  output logic                   valid_o
);

  logic [MUL_LANES*8-1:0] mul_d, mul_q;
  logic [SQ_LANES*8-1:0]  sq_d, sq_q;
  logic                   valid_q;

  // Shift-and-add: accumulate a*x^k for each set bit of b, reducing a on every shift.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // Squaring is linear: spread bits to even positions, then fold the top bits back.
  function automatic logic [7:0] gf_sq(input logic [7:0] x);
    logic [14:0] p;
    p = 15'd0;
    for (int k = 0; k < 8; k++) p[2*k] = x[k];
    for (int k = 14; k >= 8; k--) begin
      if (p[k]) p = p ^ (15'h011B << (k - 8));
    end
    return p[7:0];
  endfunction

  always_comb begin
    mul_d = mul_q;
    sq_d  = sq_q;
    if (valid_i) begin
      for (int m = 0; m < MUL_LANES; m++)
        mul_d[8*m +: 8] = gf_mul(mul_a_i[8*m +: 8], mul_b_i[8*m +: 8]);
      for (int s = 0; s < SQ_LANES; s++)
        sq_d[8*s +: 8] = gf_sq(sq_i[8*s +: 8]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mul_q   <= '0;
      sq_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      mul_q   <= mul_d;
      sq_q    <= sq_d;
      valid_q <= valid_i;
    end
  end

  assign mul_o   = mul_q;
  assign sq_o    = sq_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_gf256_arith_unit.sv
// Scoreboard bench for gf256_arith_unit: driver pushes expected results, negedge monitor pops on valid_o.
module tb_gf256_arith_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [23:0] mul_a_i = '0;
  logic [23:0] mul_b_i = '0;
  logic [31:0] sq_i = '0;
  logic [23:0] mul_o;
  logic [31:0] sq_o;
  logic        valid_o;

  typedef struct packed {
    logic [23:0] m;
    logic [31:0] s;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  gf256_arith_unit #(.MUL_LANES(3), .SQ_LANES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
    .mul_a_i(mul_a_i), .mul_b_i(mul_b_i), .sq_i(sq_i),
    .mul_o(mul_o), .sq_o(sq_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: full carry-less product, then polynomial long division by 0x11B.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'd0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 15; k >= 8; k--)
      if (p[k]) p = p ^ (16'h011B << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] ref_sq(input logic [31:0] x);
    logic [31:0] r;
    for (int s = 0; s < 4; s++) r[8*s +: 8] = ref_mul(x[8*s +: 8], x[8*s +: 8]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic issue(input logic [23:0] a, input logic [23:0] b, input logic [31:0] s, input exp_t e);
    @(posedge clk_i); #1;
    mul_a_i = a; mul_b_i = b; sq_i = s; valid_i = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  // Monitor
  always @(negedge clk_i) begin
    if (valid_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid_o", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mul_o", {8'h00, mul_o}, {8'h00, e.m});
        check("sq_o", sq_o, e.s);
      end
    end
  end

  initial begin
    #400000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] a, b;
    logic [31:0] s;
    exp_t e;

    // Power-on reset
    #1 rst_i = 1'b1;
    #1;
    check("reset_async", {7'd0, valid_o, mul_o}, 32'd0);
    check("reset_sq", sq_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Known answers: 57*83=C1, 57*13=FE, 53*CA=01; squares of 02,03,10,80
    e.m = 24'h01FEC1; e.s = 32'h9A1B0504;
    issue(24'h535757, 24'hCA1383, 32'h80100302, e);
    idle();

    // Hold with operands moving and valid_i low
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      mul_a_i = 24'($urandom); mul_b_i = 24'($urandom); sq_i = $urandom;
      @(negedge clk_i);
      check("hold_mul", {8'h00, mul_o}, 32'h0001FEC1);
      check("hold_sq", sq_o, 32'h9A1B0504);
      check("hold_valid", {31'd0, valid_o}, 32'd0);
    end

    // Async reset mid-cycle with nonzero outputs
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    check("midcycle_reset", {7'd0, valid_o, mul_o}, 32'd0);
    check("midcycle_reset_sq", sq_o, 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      check("post_reset_zero", {7'd0, valid_o, mul_o}, 32'd0);
      check("post_reset_sq", sq_o, 32'd0);
    end

    // Operation captured just before reset is discarded (not pushed to the scoreboard)
    @(posedge clk_i); #1;
    mul_a_i = 24'h535757; mul_b_i = 24'hCA1383; sq_i = 32'h80100302; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    check("discard_on_reset", {7'd0, valid_o, mul_o}, 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      check("discard_stays_zero", {7'd0, valid_o, mul_o}, 32'd0);
      check("discard_sq_zero", sq_o, 32'd0);
    end

    // Streaming: lane 0 random, lane 1 times one, lane 2 times zero
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      s = $urandom;
      e.m = {8'h00, a, ref_mul(a, b)};
      e.s = ref_sq(s);
      issue({8'($urandom), a, a}, {8'h00, 8'h01, b}, s, e);
    end
    idle();

    // Exhaustive: lane 0 (a,b), lane 1 (b,a) for commutativity, lane 2 (a,a) against sq lane 0
    for (int i = 0; i < 65536; i++) begin
      a = i[15:8]; b = i[7:0];
      s = {b, a, b, a};
      e.m = {ref_mul(a, a), ref_mul(a, b), ref_mul(a, b)};
      e.s = ref_sq(s);
      issue({a, b, a}, {a, a, b}, s, e);
    end
    idle();

    repeat (3) @(posedge clk_i);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
